pipe_mw_skid_stage: RTL

//  Parametrised MEM->WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_mw_skid_stage_if.sv | 45 ++++
 rtl/pipe_mw_skid_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_mw_skid_stage_if.sv
// MEM->WB handshake bundle: upstream entry fields, downstream registered copies and
// the valid/ready pairs for both sides.
interface pipe_mw_skid_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               in_mux_sel;
  logic               in_rf_wena;
  logic [RADDR_W-1:0] in_rf_waddr;
  logic               in_hi_ena;
  logic [DATA_W-1:0]  in_hi_data;
  logic               in_lo_ena;
  logic [DATA_W-1:0]  in_lo_data;
  logic [DATA_W-1:0]  in_exe_out;
  logic [DATA_W-1:0]  in_mem_rdata;

  logic               out_valid;
  logic               out_ready;
  logic               out_mux_sel;
  logic               out_rf_wena;
  logic [RADDR_W-1:0] out_rf_waddr;
  logic               out_hi_ena;
  logic [DATA_W-1:0]  out_hi_data;
  logic               out_lo_ena;
  logic [DATA_W-1:0]  out_lo_data;
  logic [DATA_W-1:0]  out_exe_out;
  logic [DATA_W-1:0]  out_mem_rdata;
  logic [DATA_W-1:0]  out_wb_data;

  modport master (
    output in_valid, in_mux_sel, in_rf_wena, in_rf_waddr, in_hi_ena, in_hi_data,
           in_lo_ena, in_lo_data, in_exe_out, in_mem_rdata, out_ready,
    input  in_ready, out_valid, out_mux_sel, out_rf_wena, out_rf_waddr, out_hi_ena,
           out_hi_data, out_lo_ena, out_lo_data, out_exe_out, out_mem_rdata, out_wb_data
  );

  modport slave (
    input  in_valid, in_mux_sel, in_rf_wena, in_rf_waddr, in_hi_ena, in_hi_data,
           in_lo_ena, in_lo_data, in_exe_out, in_mem_rdata, out_ready,
    output in_ready, out_valid, out_mux_sel, out_rf_wena, out_rf_waddr, out_hi_ena,
           out_hi_data, out_lo_ena, out_lo_data, out_exe_out, out_mem_rdata, out_wb_data
  );
endinterface

// File: rtl/pipe_mw_skid_stage.sv
// MEM->WB pipeline stage with a 2-entry skid buffer, synchronous flush and a
// writeback data select driven only from registered fields.
module pipe_mw_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  pipe_mw_skid_stage_if.slave    bus,
  output logic [1:0]             occupancy_o
);

  typedef struct packed {
    logic               mux_sel;
    logic               rf_wena;
    logic [RADDR_W-1:0] rf_waddr;
    logic               hi_ena;
    logic [DATA_W-1:0]  hi_data;
    logic               lo_ena;
    logic [DATA_W-1:0]  lo_data;
    logic [DATA_W-1:0]  exe_out;
    logic [DATA_W-1:0]  mem_rdata;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_ent;
  logic   valid_q;
  logic   ready_q;
  logic   accept;
  logic   consume;

  assign in_ent = '{
    mux_sel:   bus.in_mux_sel,
    rf_wena:   bus.in_rf_wena,
    rf_waddr:  bus.in_rf_waddr,
    hi_ena:    bus.in_hi_ena,
    hi_data:   bus.in_hi_data,
    lo_ena:    bus.in_lo_ena,
    lo_data:   bus.in_lo_data,
    exe_out:   bus.in_exe_out,
    mem_rdata: bus.in_mem_rdata
  };

  // A flushed-cycle accept is dropped here so it can never reach storage.
  assign accept  = bus.in_valid & ready_q & ~flush_i;
  assign consume = valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_ent;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = in_ent;
        end else if (accept) begin
          skid_d  = in_ent;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign occupancy_o       = state_q;
  assign bus.in_ready      = ready_q;
  assign bus.out_valid     = valid_q;
  assign bus.out_mux_sel   = main_q.mux_sel;
  assign bus.out_rf_waddr  = main_q.rf_waddr;
  assign bus.out_hi_data   = main_q.hi_data;
  assign bus.out_lo_data   = main_q.lo_data;
  assign bus.out_exe_out   = main_q.exe_out;
  assign bus.out_mem_rdata = main_q.mem_rdata;
  // Enables are gated so stale data left behind by a flush never writes.
  assign bus.out_rf_wena   = main_q.rf_wena & valid_q;
  assign bus.out_hi_ena    = main_q.hi_ena & valid_q;
  assign bus.out_lo_ena    = main_q.lo_ena & valid_q;
  assign bus.out_wb_data   = main_q.mux_sel ? main_q.mem_rdata : main_q.exe_out;

endmodule
